load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 197 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit between a CPU request port and a word-wide DataMemory; optional misalignment trap under LSU_MISALIGN_CHK_EN.
// Latency: load WAIT_CYCLES+1, word store 2, sub-word store WAIT_CYCLES+2 (read-modify-write), trapped misalign 1.
// Backpressure: one request in flight; ReqReady only in IDLE, ReqValid ignored elsewhere.
module load_store_unit #(
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        ReqValid,
    output logic        ReqReady,
    input  logic        ReqWrite,
    input  logic [1:0]  ReqSize,
    input  logic        ReqSigned,
    input  logic [31:0] ReqAddr,
    input  logic [31:0] ReqWData,
    output logic        RespValid,
    output logic [31:0] RespData,
    output logic        RespErr,
    output logic        RW,
    output logic [31:0] DAddr,
    output logic [31:0] Datain,
    input  logic [31:0] DataOut
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        live_q;
    logic        write_q, write_d;
    logic [1:0]  size_q, size_d;
    logic        signed_q, signed_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rdata_q, rdata_d;
    logic [3:0]  cnt_q, cnt_d;
`ifdef LSU_MISALIGN_CHK_EN
    logic        err_q, err_d;
    logic        req_misal;
`endif

    logic        accept;
    logic        req_word;
    logic [7:0]  load_byte;
    logic [15:0] load_half;
    logic [31:0] load_data;
    logic [31:0] merge_word;

    // ReqReady stays low until the first edge after reset release
    assign ReqReady = live_q && (state_q == IDLE);
    assign accept   = ReqValid && ReqReady;
    assign req_word = ReqSize[1];

`ifdef LSU_MISALIGN_CHK_EN
    assign req_misal = ((ReqSize == 2'b01) && ReqAddr[0]) ||
                       (req_word && (ReqAddr[1:0] != 2'b00));
`endif

    always_comb begin
        state_d  = state_q;
        write_d  = write_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;
        cnt_d    = cnt_q;
`ifdef LSU_MISALIGN_CHK_EN
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    write_d  = ReqWrite;
                    size_d   = ReqSize;
                    signed_d = ReqSigned;
                    addr_d   = ReqAddr;
                    wdata_d  = ReqWData;
                    cnt_d    = 4'(WAIT_CYCLES - 1);
`ifdef LSU_MISALIGN_CHK_EN
                    err_d    = req_misal;
                    if (req_misal) begin
                        state_d = RESP;
                    end else
`endif
                    if (ReqWrite && req_word) begin
                        state_d = WRITE;
                    end else begin
                        state_d = READ;
                    end
                end
            end
            READ: begin
                if (cnt_q == 4'd0) begin
                    rdata_d = DataOut;
                    state_d = write_q ? WRITE : RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            WRITE:   state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            live_q   <= 1'b0;
            write_q  <= 1'b0;
            size_q   <= 2'b00;
            signed_q <= 1'b0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            cnt_q    <= 4'd0;
`ifdef LSU_MISALIGN_CHK_EN
            err_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            live_q   <= 1'b1;
            write_q  <= write_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            rdata_q  <= rdata_d;
            cnt_q    <= cnt_d;
`ifdef LSU_MISALIGN_CHK_EN
            err_q    <= err_d;
`endif
        end
    end

    // Little-endian lane select for loads
    always_comb begin
        load_byte = rdata_q[7:0];
        case (addr_q[1:0])
            2'd0: load_byte = rdata_q[7:0];
            2'd1: load_byte = rdata_q[15:8];
            2'd2: load_byte = rdata_q[23:16];
            2'd3: load_byte = rdata_q[31:24];
            default: load_byte = rdata_q[7:0];
        endcase
        load_half = addr_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        case (size_q)
            2'b00:   load_data = {{24{signed_q & load_byte[7]}}, load_byte};
            2'b01:   load_data = {{16{signed_q & load_half[15]}}, load_half};
            default: load_data = rdata_q;
        endcase
    end

    // Sub-word stores patch their lane into the word captured during READ
    always_comb begin
        merge_word = rdata_q;
        case (size_q)
            2'b00: begin
                case (addr_q[1:0])
                    2'd0: merge_word[7:0]   = wdata_q[7:0];
                    2'd1: merge_word[15:8]  = wdata_q[7:0];
                    2'd2: merge_word[23:16] = wdata_q[7:0];
                    2'd3: merge_word[31:24] = wdata_q[7:0];
                    default: merge_word[7:0] = wdata_q[7:0];
                endcase
            end
            2'b01: begin
                if (addr_q[1]) begin
                    merge_word[31:16] = wdata_q[15:0];
                end else begin
                    merge_word[15:0] = wdata_q[15:0];
                end
            end
            default: merge_word = wdata_q;
        endcase
    end

    // Memory-side outputs decode straight from state so reset drops them at once
    assign RW        = (state_q == WRITE);
    assign DAddr     = ((state_q == READ) || (state_q == WRITE)) ? {addr_q[31:2], 2'b00} : 32'd0;
    assign Datain    = (state_q == WRITE) ? merge_word : 32'd0;
    assign RespValid = (state_q == RESP);

`ifdef LSU_MISALIGN_CHK_EN
    assign RespErr  = (state_q == RESP) && err_q;
    assign RespData = ((state_q == RESP) && !write_q && !err_q) ? load_data : 32'd0;
`else
    assign RespErr  = 1'b0;
    assign RespData = ((state_q == RESP) && !write_q) ? load_data : 32'd0;
`endif

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, hand sequences for reset/held requests, randomized traffic vs a word-array model.
module tb_load_store_unit;

    localparam int WC = 2;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic        ReqWrite;
    logic [1:0]  ReqSize;
    logic        ReqSigned;
    logic [31:0] ReqAddr;
    logic [31:0] ReqWData;
    logic        RespValid;
    logic [31:0] RespData;
    logic        RespErr;
    logic        RW;
    logic [31:0] DAddr;
    logic [31:0] Datain;
    logic [31:0] DataOut;

    load_store_unit #(.WAIT_CYCLES(WC)) dut (
        .CLK(CLK), .Reset(Reset),
        .ReqValid(ReqValid), .ReqReady(ReqReady), .ReqWrite(ReqWrite),
        .ReqSize(ReqSize), .ReqSigned(ReqSigned), .ReqAddr(ReqAddr), .ReqWData(ReqWData),
        .RespValid(RespValid), .RespData(RespData), .RespErr(RespErr),
        .RW(RW), .DAddr(DAddr), .Datain(Datain), .DataOut(DataOut)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'h8899AABB;
        return (32'h01010101 * i) ^ 32'h5A5A3C3C;
    endfunction

    // DataMemory stand-in: combinational read, write on the edge ending an RW=1 cycle
    logic [31:0] mem [0:63];
    assign DataOut = mem[DAddr[7:2]];
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = init_word(i);
        forever begin
            @(posedge CLK);
            if (RW) mem[DAddr[7:2]] = Datain;
        end
    end

    logic [31:0] ref_mem [0:63];
    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, got, exp);
    endtask

    // Reference: expected response computed from byte-lane arithmetic on a word array
    task automatic model(input logic wr, input logic [1:0] sz, input logic sg,
                         input logic [31:0] ad, input logic [31:0] wd,
                         output logic [31:0] e_data, output logic e_err, output int e_lat,
                         output int e_nrw, output logic [31:0] e_din);
        logic [31:0] word, mask, lane;
        int nbytes, off;
        logic misal;
        word   = ref_mem[ad[7:2]];
        nbytes = sz[1] ? 4 : (sz == 2'b01 ? 2 : 1);
        off    = (nbytes == 4) ? 0 : (nbytes == 2 ? 2 * int'(ad[1]) : int'(ad[1:0]));
`ifdef LSU_MISALIGN_CHK_EN
        misal = (nbytes == 2 && ad[0]) || (nbytes == 4 && ad[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        e_data = 32'd0; e_err = 1'b0; e_nrw = 0; e_din = 32'd0;
        if (misal) begin
            e_err = 1'b1; e_lat = 1;
            return;
        end
        mask = (nbytes == 4) ? 32'hFFFFFFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
        lane = (word >> (8 * off)) & mask;
        if (!wr) begin
            e_lat  = WC + 1;
            e_data = (sg && ((lane >> (8 * nbytes - 1)) & 32'd1) != 0) ? (lane | ~mask) : lane;
        end else begin
            e_lat = (nbytes == 4) ? 2 : WC + 2;
            e_nrw = 1;
            e_din = (nbytes == 4) ? wd : ((word & ~(mask << (8 * off))) | ((wd & mask) << (8 * off)));
            ref_mem[ad[7:2]] = e_din;
        end
    endtask

    task automatic run_req(input logic wr, input logic [1:0] sz, input logic sg,
                           input logic [31:0] ad, input logic [31:0] wd,
                           output logic [31:0] rdata, output logic rerr, output int lat,
                           output int nrw, output logic [31:0] din,
                           output logic [31:0] c1_addr, output logic c1_rw,
                           output logic bad_rdy, output logic bad_idle);
        int g;
        rdata = 32'd0; rerr = 1'b0; lat = 0; nrw = 0; din = 32'd0;
        c1_addr = 32'd0; c1_rw = 1'b0; bad_rdy = 1'b0; bad_idle = 1'b0;
        @(negedge CLK);
        ReqValid = 1'b1; ReqWrite = wr; ReqSize = sz; ReqSigned = sg; ReqAddr = ad; ReqWData = wd;
        g = 0;
        while (!ReqReady && g < 20) begin @(negedge CLK); g++; end
        @(posedge CLK);
        #1 ReqValid = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge CLK);
            if (k == 1) begin c1_addr = DAddr; c1_rw = RW; end
            if (ReqReady) bad_rdy = 1'b1;
            if (RW) begin nrw++; din = Datain; end
            if (RespValid) begin
                lat = k; rdata = RespData; rerr = RespErr;
                if (RW || DAddr != 32'd0 || Datain != 32'd0) bad_idle = 1'b1;
                break;
            end
        end
    endtask

    task automatic check_txn(input string tag, input logic wr, input logic [1:0] sz,
                             input logic [31:0] ad, input logic [31:0] wd,
                             input logic [31:0] e_data, input logic e_err, input int e_lat,
                             input logic [31:0] e_din);
        logic [31:0] rdata, din, c1a; logic rerr, c1rw, brdy, bidle; int lat, nrw;
        run_req(wr, sz, ReqSigned, ad, wd, rdata, rerr, lat, nrw, din, c1a, c1rw, brdy, bidle);
        chk({tag, " data"}, rdata, e_data);
        chk({tag, " err"}, 32'(rerr), 32'(e_err));
        chk({tag, " latency"}, 32'(lat), 32'(e_lat));
        chk({tag, " rw_cycles"}, 32'(nrw), (wr && !e_err) ? 32'd1 : 32'd0);
        if (wr && !e_err) chk({tag, " datain"}, din, e_din);
        chk({tag, " first_daddr"}, c1a, e_err ? 32'd0 : {ad[31:2], 2'b00});
        chk({tag, " first_rw"}, 32'(c1rw), 32'(wr && sz[1] && !e_err));
        chk({tag, " ready_low"}, 32'(brdy), 32'd0);
        chk({tag, " resp_bus_idle"}, 32'(bidle), 32'd0);
    endtask

    typedef struct {
        logic        wr;
        logic [1:0]  sz;
        logic        sg;
        logic [31:0] ad;
        logic [31:0] wd;
        logic [31:0] e_data;
        logic        e_err;
        int          e_lat;
        logic [31:0] e_din;
    } vec_t;

    vec_t vt [12];

    initial begin
        logic [31:0] md, mdin; logic merr; int mlat, mnrw; int rv_seen, diffs;
        logic wr, sg; logic [1:0] sz; logic [31:0] ad, wd;

        for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
        Reset = 1'b0; ReqValid = 1'b0; ReqWrite = 1'b0; ReqSize = 2'b00;
        ReqSigned = 1'b0; ReqAddr = 32'd0; ReqWData = 32'd0;

        vt[0]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h8899AABB, 1'b0, WC + 1, 32'h0};
        vt[1]  = '{1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'hFFFFFF88, 1'b0, WC + 1, 32'h0};
        vt[2]  = '{1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000088, 1'b0, WC + 1, 32'h0};
        vt[3]  = '{1'b1, 2'b01, 1'b0, 32'h12, 32'h1234, 32'h0, 1'b0, WC + 2, 32'h1234AABB};
        vt[4]  = '{1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1234AABB, 1'b0, WC + 1, 32'h0};
        vt[5]  = '{1'b1, 2'b10, 1'b0, 32'h20, 32'hDEADBEEF, 32'h0, 1'b0, 2, 32'hDEADBEEF};
`ifdef LSU_MISALIGN_CHK_EN
        vt[6]  = '{1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'h0, 1'b1, 1, 32'h0};
`else
        vt[6]  = '{1'b0, 2'b10, 1'b0, 32'h22, 32'h0, 32'hDEADBEEF, 1'b0, WC + 1, 32'h0};
`endif
        vt[7]  = '{1'b0, 2'b01, 1'b1, 32'h20, 32'h0, 32'hFFFFBEEF, 1'b0, WC + 1, 32'h0};
        vt[8]  = '{1'b0, 2'b00, 1'b0, 32'h21, 32'h0, 32'h000000BE, 1'b0, WC + 1, 32'h0};
        vt[9]  = '{1'b1, 2'b00, 1'b0, 32'h21, 32'hFFFFFF5A, 32'h0, 1'b0, WC + 2, 32'hDEAD5AEF};
        vt[10] = '{1'b0, 2'b01, 1'b1, 32'h22, 32'h0, 32'hFFFFDEAD, 1'b0, WC + 1, 32'h0};
        vt[11] = '{1'b0, 2'b11, 1'b0, 32'h20, 32'h0, 32'hDEAD5AEF, 1'b0, WC + 1, 32'h0};

        // Reset state
        #12;
        chk("rst ReqReady", 32'(ReqReady), 32'd0);
        chk("rst RespValid", 32'(RespValid), 32'd0);
        chk("rst RespData", RespData, 32'd0);
        chk("rst RespErr", 32'(RespErr), 32'd0);
        chk("rst RW", 32'(RW), 32'd0);
        chk("rst DAddr", DAddr, 32'd0);
        chk("rst Datain", Datain, 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        #1 chk("ready before first edge", 32'(ReqReady), 32'd0);
        @(posedge CLK);
        #1 chk("ready after first edge", 32'(ReqReady), 32'd1);

        // Directed table
        for (int i = 0; i < 12; i++) begin
            ReqSigned = vt[i].sg;
            check_txn($sformatf("vec%0d", i), vt[i].wr, vt[i].sz, vt[i].ad, vt[i].wd,
                      vt[i].e_data, vt[i].e_err, vt[i].e_lat, vt[i].e_din);
            model(vt[i].wr, vt[i].sz, vt[i].sg, vt[i].ad, vt[i].wd, md, merr, mlat, mnrw, mdin);
        end

        // Request held high: accepted again in the cycle after RESP
        @(negedge CLK);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b10; ReqSigned = 1'b0;
        ReqAddr = 32'h44; ReqWData = 32'h11223344;
        chk("held c0 ready", 32'(ReqReady), 32'd1);
        @(negedge CLK); chk("held c1 rw", 32'(RW), 32'd1); chk("held c1 ready", 32'(ReqReady), 32'd0);
        @(negedge CLK); chk("held c2 resp", 32'(RespValid), 32'd1); chk("held c2 ready", 32'(ReqReady), 32'd0);
        @(negedge CLK); chk("held c3 ready", 32'(ReqReady), 32'd1); chk("held c3 resp", 32'(RespValid), 32'd0);
        chk("held c3 rw", 32'(RW), 32'd0);
        @(negedge CLK); chk("held c4 rw", 32'(RW), 32'd1);
        ReqValid = 1'b0;
        @(negedge CLK); @(negedge CLK);
        model(1'b1, 2'b10, 1'b0, 32'h44, 32'h11223344, md, merr, mlat, mnrw, mdin);

        // Reset in the WRITE cycle aborts the store
        @(negedge CLK);
        ReqValid = 1'b1; ReqWrite = 1'b1; ReqSize = 2'b10; ReqAddr = 32'h40; ReqWData = 32'hCAFEF00D;
        @(posedge CLK);
        #1 ReqValid = 1'b0;
        @(negedge CLK);
        chk("abort write rw", 32'(RW), 32'd1);
        chk("abort write daddr", DAddr, 32'h40);
        #1 Reset = 1'b0;
        #1 chk("abort rw dropped", 32'(RW), 32'd0);
        chk("abort daddr zero", DAddr, 32'd0);
        chk("abort datain zero", Datain, 32'd0);
        @(negedge CLK);
        Reset = 1'b1;
        @(posedge CLK);
        #1 chk("abort ready after release", 32'(ReqReady), 32'd1);
        rv_seen = 0;
        for (int k = 0; k < 4; k++) begin @(negedge CLK); if (RespValid) rv_seen++; end
        chk("abort no resp", 32'(rv_seen), 32'd0);
        ReqSigned = 1'b0;
        model(1'b0, 2'b10, 1'b0, 32'h40, 32'h0, md, merr, mlat, mnrw, mdin);
        check_txn("abort readback", 1'b0, 2'b10, 32'h40, 32'h0, md, merr, mlat, mdin);

        // Randomized traffic
        for (int i = 0; i < 80; i++) begin
            wr = 1'($urandom); sz = 2'($urandom); sg = 1'($urandom);
            ad = $urandom; wd = $urandom;
            model(wr, sz, sg, ad, wd, md, merr, mlat, mnrw, mdin);
            ReqSigned = sg;
            check_txn($sformatf("rnd%0d", i), wr, sz, ad, wd, md, merr, mlat, mdin);
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) @(negedge CLK);
        end

        diffs = 0;
        for (int i = 0; i < 64; i++) if (mem[i] !== ref_mem[i]) diffs++;
        chk("memory image", 32'(diffs), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
